matrix_scan_ctrl: RTL and testbench

Row-scan sequencer for the 8x8 LED matrix display. Holds the currently displayed frame plus one pending frame from game logic. Steps through rows with a programmable dwell time and drives active-low row and column lines. New frames are swapped in only at frame boundaries, so a frame is never displayed partially (no tearing).

---
 rtl/matrix_scan_ctrl.sv | 113 +++++++++++
 tb/tb_matrix_scan_ctrl.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/matrix_scan_ctrl.sv
// Row-scan sequencer for an LED matrix with a single pending-frame slot.
// Optional inter-row blanking is compiled in with `define SCAN_BLANK_EN.
module matrix_scan_ctrl #(
    parameter int ROW       = 8,
    parameter int COL       = 8,
    parameter int BIT_COUNT = 3,
    parameter int DWELL     = 1000,
    parameter int BLANK     = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [ROW*COL-1:0]   frame_in,
    input  logic                 frame_valid,
    output logic                 frame_ready,
    output logic [ROW-1:0]       row_n,
    output logic [COL-1:0]       col_n,
    output logic [BIT_COUNT-1:0] count_row,
    output logic                 frame_done
);

    localparam int CMAX = (DWELL > BLANK) ? DWELL : BLANK;
    localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;

`ifdef SCAN_BLANK_EN
    typedef enum logic {S_DRIVE, S_BLANK} state_t;
`else
    typedef enum logic {S_DRIVE} state_t;
`endif

    state_t               r_state, w_state_nxt;
    logic [BIT_COUNT-1:0] r_row, w_row_nxt;
    logic [CW-1:0]        r_cnt, w_cnt_nxt;
    logic [ROW*COL-1:0]   r_active;
    logic [ROW*COL-1:0]   r_pending;
    logic                 r_pend_vld;
    logic                 r_frame_done;
    logic                 w_boundary;

    always_comb begin
        w_state_nxt = r_state;
        w_row_nxt   = r_row;
        w_cnt_nxt   = r_cnt + 1'b1;
        w_boundary  = 1'b0;
        case (r_state)
            S_DRIVE: begin
                if (r_cnt == CW'(DWELL - 1)) begin
                    w_cnt_nxt  = '0;
                    w_row_nxt  = (r_row == BIT_COUNT'(ROW - 1)) ? '0 : r_row + 1'b1;
                    w_boundary = (r_row == BIT_COUNT'(ROW - 1));
`ifdef SCAN_BLANK_EN
                    w_state_nxt = S_BLANK;
`endif
                end
            end
`ifdef SCAN_BLANK_EN
            S_BLANK: begin
                if (r_cnt == CW'(BLANK - 1)) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_DRIVE;
                end
            end
`endif
            default: begin
                w_state_nxt = S_DRIVE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_DRIVE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Swap needs pend_vld=1 and capture needs pend_vld=0, so they never coincide.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_row        <= '0;
            r_cnt        <= '0;
            r_active     <= '0;
            r_pending    <= '0;
            r_pend_vld   <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_row        <= w_row_nxt;
            r_cnt        <= w_cnt_nxt;
            r_frame_done <= w_boundary;
            if (w_boundary && r_pend_vld) begin
                r_active   <= r_pending;
                r_pend_vld <= 1'b0;
            end else if (frame_valid && !r_pend_vld) begin
                r_pending  <= frame_in;
                r_pend_vld <= 1'b1;
            end
        end
    end

    always_comb begin
        frame_ready = ~r_pend_vld;
        count_row   = r_row;
        frame_done  = r_frame_done;
        row_n       = '1;
        col_n       = '1;
        if (r_state == S_DRIVE) begin
            row_n = ~(ROW'(1) << r_row);
            col_n = ~r_active[r_row*COL +: COL];
        end
    end

endmodule

// File: tb/tb_matrix_scan_ctrl.sv
// Randomized bench for matrix_scan_ctrl against a time-position frame model.
// Honors `define SCAN_BLANK_EN the same way as the design.
module tb_matrix_scan_ctrl;

    localparam int ROW   = 8;
    localparam int COL   = 8;
    localparam int BC    = 3;
    localparam int DWELL = 4;
    localparam int BLANK = 2;
`ifdef SCAN_BLANK_EN
    localparam int BL = BLANK;
`else
    localparam int BL = 0;
`endif
    localparam int SLOT = DWELL + BL;
    localparam int PER  = ROW * SLOT;
    localparam int BND  = (ROW - 1) * SLOT + DWELL - 1;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [ROW*COL-1:0]   frame_in;
    logic                 frame_valid;
    logic                 frame_ready;
    logic [ROW-1:0]       row_n;
    logic [COL-1:0]       col_n;
    logic [BC-1:0]        count_row;
    logic                 frame_done;

    matrix_scan_ctrl #(
        .ROW(ROW), .COL(COL), .BIT_COUNT(BC), .DWELL(DWELL), .BLANK(BLANK)
    ) dut (
        .clk(clk), .rst(rst), .frame_in(frame_in), .frame_valid(frame_valid),
        .frame_ready(frame_ready), .row_n(row_n), .col_n(col_n),
        .count_row(count_row), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_err    = 0;

    // Reference: position within the frame period since reset, plus frame slots.
    int unsigned        m_t;
    logic [ROW*COL-1:0] m_active;
    logic [ROW*COL-1:0] m_pending;
    logic               m_pvld;
    logic               m_done;
    logic               m_known = 1'b0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp);
        end
    endtask

    task automatic check_outputs();
        int unsigned r, w;
        logic [ROW-1:0] e_row;
        logic [COL-1:0] e_col;
        int unsigned    e_cr;
        r = m_t / SLOT;
        w = m_t % SLOT;
        if (w < DWELL) begin
            e_row = ~(ROW'(1) << r);
            e_col = ~m_active[r*COL +: COL];
            e_cr  = r;
        end else begin
            e_row = '1;
            e_col = '1;
            e_cr  = (r + 1) % ROW;
        end
        check("row_n", 64'(row_n), 64'(e_row));
        check("col_n", 64'(col_n), 64'(e_col));
        check("count_row", 64'(count_row), 64'(e_cr));
        check("frame_ready", 64'(frame_ready), 64'(!m_pvld));
        check("frame_done", 64'(frame_done), 64'(m_done));
    endtask

    task automatic tick(input logic r, input logic v, input logic [ROW*COL-1:0] f);
        logic bnd;
        rst = r; frame_valid = v; frame_in = f;
        @(posedge clk);
        if (r) begin
            m_t = 0; m_active = '0; m_pending = '0; m_pvld = 1'b0; m_done = 1'b0;
            m_known = 1'b1;
        end else if (m_known) begin
            bnd    = (m_t == BND);
            m_done = bnd;
            if (bnd && m_pvld) begin
                m_active = m_pending;
                m_pvld   = 1'b0;
            end else if (v && !m_pvld) begin
                m_pending = f;
                m_pvld    = 1'b1;
            end
            m_t = (m_t + 1) % PER;
        end
        @(negedge clk);
        if (m_known) check_outputs();
    endtask

    function automatic logic [ROW*COL-1:0] rnd_frame();
        return {$urandom, $urandom};
    endfunction

    task automatic offer_until_taken(input logic [ROW*COL-1:0] f, input string tag);
        int unsigned k;
        for (k = 0; k < 4*PER; k++) begin
            if (!m_pvld) break;
            tick(1'b0, 1'b1, f);
        end
        check({tag, "_wait"}, 64'(m_pvld), 64'(1'b0));
        tick(1'b0, 1'b1, f);
    endtask

    initial begin
        logic [ROW*COL-1:0] fa, fb, hold;
        logic holding;
        logic found;
        rst = 1'b1; frame_valid = 1'b0; frame_in = '0;
        @(negedge clk);

        tick(1'b1, 1'b0, '0);
        tick(1'b1, 1'b0, '0);
        check("rst_row_n", 64'(row_n), 64'h0000_0000_0000_00FE);
        check("rst_col_n", 64'(col_n), 64'h0000_0000_0000_00FF);
        check("rst_ready", 64'(frame_ready), 64'd1);
        check("rst_done", 64'(frame_done), 64'd0);

        for (int i = 0; i < 2*PER + 3; i++) tick(1'b0, 1'b0, '0);

        while (m_t != 10) tick(1'b0, 1'b0, '0);
        tick(1'b0, 1'b1, 64'h0000_0000_0000_00A5);
        check("load_ready_low", 64'(frame_ready), 64'd0);
        for (int i = 0; i < 2*PER; i++) tick(1'b0, 1'b0, '0);

        fa = rnd_frame();
        fb = rnd_frame();
        tick(1'b0, 1'b1, fa);
        offer_until_taken(fb, "bp_b");
        for (int i = 0; i < 3*PER; i++) tick(1'b0, 1'b0, '0);

        while (m_t != 2) tick(1'b0, 1'b0, '0);
        tick(1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF);
        found = 1'b0;
        for (int i = 0; i < 4*PER; i++) begin
            if ((m_t / SLOT) == 5 && m_pvld) begin
                found = 1'b1;
                break;
            end
            tick(1'b0, 1'b0, '0);
        end
        check("midrst_found", 64'(found), 64'd1);
        tick(1'b1, 1'b0, '0);
        check("midrst_row_n", 64'(row_n), 64'h0000_0000_0000_00FE);
        check("midrst_col_n", 64'(col_n), 64'h0000_0000_0000_00FF);
        check("midrst_ready", 64'(frame_ready), 64'd1);
        for (int i = 0; i < 2*PER; i++) begin
            tick(1'b0, 1'b0, '0);
            check("midrst_dark", 64'(col_n), 64'h0000_0000_0000_00FF);
        end

        holding = 1'b0;
        hold    = '0;
        for (int i = 0; i < 30*PER; i++) begin
            if (!holding && $urandom_range(0, 9) == 0) begin
                hold    = rnd_frame();
                holding = 1'b1;
            end
            if (holding) begin
                if (!m_pvld) begin
                    tick(1'b0, 1'b1, hold);
                    holding = 1'b0;
                end else begin
                    tick(1'b0, 1'b1, hold);
                end
            end else if ($urandom_range(0, 199) == 0) begin
                tick(1'b1, 1'b0, '0);
            end else begin
                tick(1'b0, $urandom_range(0, 3) == 0 && m_pvld, rnd_frame());
            end
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
